// File: rtl/encrypt_rotor_sched.sv
// Front-end controller for the encrypt shift pipeline: latches configuration, steps three
// odometer-style rotors and issues one byte per cycle under a credit limit sized to pipe depth.
module encrypt_rotor_sched #(
  parameter int CREDITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_load,
  input  logic [7:0] cfg_k1,
  input  logic [7:0] cfg_k2,
  input  logic [7:0] cfg_k3,
  input  logic [2:0] cfg_rot_freq,
  input  logic       cfg_shift_en,
  input  logic       cfg_mode,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       ret_credit,
  output logic       pipe_en,
  output logic [7:0] pipe_din,
  output logic [7:0] pipe_k1,
  output logic [7:0] pipe_k2,
  output logic [7:0] pipe_k3,
  output logic [2:0] pipe_rot_freq,
  output logic       pipe_shift_en,
  output logic [3:0] pipe_shift_amt,
  output logic       pipe_mode,
  output logic       busy,
  output logic       credit_err,
  output logic [1:0] dbg_state
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_FULL = CW'(CREDITS);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready; in_ready
  // depends only on registered state and credits, and in_valid must hold until accepted.
  typedef enum logic [1:0] {UNCFG = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   credits;
  logic [7:0]      r1, r2, r3;
  logic [2:0]      step_cnt;
  logic [2:0]      act_rf;
  logic            act_se, act_mode;
  logic [7:0]      pend_k1, pend_k2, pend_k3;
  logic [2:0]      pend_rf;
  logic            pend_se, pend_mode;

  logic            accept, credits_full, apply_cfg, is_alpha;
  logic [7:0]      red_k1, red_k2, red_k3;
  logic [7:0]      src_k1, src_k2, src_k3;
  logic [2:0]      src_rf;
  logic            src_se, src_mode;
  logic [6:0]      rot_sum;

  function automatic logic [7:0] mod26(input logic [7:0] v);
    return v % 8'd26;
  endfunction

  assign red_k1       = mod26(cfg_k1);
  assign red_k2       = mod26(cfg_k2);
  assign red_k3       = mod26(cfg_k3);
  assign credits_full = (credits == CRED_FULL);
  assign in_ready     = (state == RUN) && (credits != '0);
  assign accept       = in_valid && in_ready;
  assign busy         = (state != RUN) || !credits_full;
  assign dbg_state    = state;
  assign is_alpha     = ((in_data >= 8'd65) && (in_data <= 8'd90)) ||
                        ((in_data >= 8'd97) && (in_data <= 8'd122));
  assign rot_sum      = 7'(r1) + 7'(r2) + 7'(r3);

  // A cfg_load arriving in the same cycle the drain completes is the newest, so it wins.
  assign src_k1   = cfg_load ? red_k1 : pend_k1;
  assign src_k2   = cfg_load ? red_k2 : pend_k2;
  assign src_k3   = cfg_load ? red_k3 : pend_k3;
  assign src_rf   = cfg_load ? cfg_rot_freq : pend_rf;
  assign src_se   = cfg_load ? cfg_shift_en : pend_se;
  assign src_mode = cfg_load ? cfg_mode : pend_mode;
  assign apply_cfg = ((state == UNCFG) && cfg_load) || ((state == DRAIN) && credits_full);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= UNCFG;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      UNCFG:   if (cfg_load)     state_nxt = RUN;
      RUN:     if (cfg_load)     state_nxt = DRAIN;
      DRAIN:   if (credits_full) state_nxt = RUN;
      default:                   state_nxt = UNCFG;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits    <= CRED_FULL;
      credit_err <= 1'b0;
    end else begin
      case ({accept, ret_credit})
        2'b10: credits <= credits - CW'(1);
        2'b01: begin
          if (credits_full) credit_err <= 1'b1;
          else              credits    <= credits + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_k1   <= '0;
      pend_k2   <= '0;
      pend_k3   <= '0;
      pend_rf   <= '0;
      pend_se   <= 1'b0;
      pend_mode <= 1'b0;
    end else if (cfg_load) begin
      pend_k1   <= red_k1;
      pend_k2   <= red_k2;
      pend_k3   <= red_k3;
      pend_rf   <= cfg_rot_freq;
      pend_se   <= cfg_shift_en;
      pend_mode <= cfg_mode;
    end
  end

  // Rotors and step counter; accepts never coincide with apply_cfg (in_ready is low then).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1       <= '0;
      r2       <= '0;
      r3       <= '0;
      step_cnt <= '0;
      act_rf   <= '0;
      act_se   <= 1'b0;
      act_mode <= 1'b0;
    end else if (apply_cfg) begin
      r1       <= src_k1;
      r2       <= src_k2;
      r3       <= src_k3;
      step_cnt <= '0;
      act_rf   <= src_rf;
      act_se   <= src_se;
      act_mode <= src_mode;
    end else if (accept && act_se && is_alpha) begin
      if (step_cnt == act_rf) begin
        step_cnt <= '0;
        if (r1 == 8'd25) begin
          r1 <= '0;
          if (r2 == 8'd25) begin
            r2 <= '0;
            r3 <= (r3 == 8'd25) ? 8'd0 : r3 + 8'd1;
          end else begin
            r2 <= r2 + 8'd1;
          end
        end else begin
          r1 <= r1 + 8'd1;
        end
      end else begin
        step_cnt <= step_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_en        <= 1'b0;
      pipe_din       <= '0;
      pipe_k1        <= '0;
      pipe_k2        <= '0;
      pipe_k3        <= '0;
      pipe_rot_freq  <= '0;
      pipe_shift_en  <= 1'b0;
      pipe_shift_amt <= '0;
      pipe_mode      <= 1'b0;
    end else begin
      pipe_en <= accept;
      if (accept) begin
        pipe_din       <= in_data;
        pipe_k1        <= r1;
        pipe_k2        <= r2;
        pipe_k3        <= r3;
        pipe_rot_freq  <= act_rf;
        pipe_shift_en  <= act_se;
        pipe_shift_amt <= rot_sum[3:0];
        pipe_mode      <= act_mode;
      end
    end
  end
endmodule

// File: doc/encrypt_rotor_sched.md
Name: encrypt_rotor_sched

Overview:
- Front-end controller for the encrypt shift pipeline.
- Accepts configuration (rotor start keys, rotation frequency, shift enable, mode) and a valid/ready byte stream.
- Issues one byte per cycle into the pipe's first stage, together with the current rotor positions and a derived shift amount.
- Steps the three rotors odometer-style and throttles issue with a credit counter sized to pipeline depth.

Parameters:
- CREDITS, 4, max bytes in flight in the pipe; credit counter width is clog2(CREDITS+1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cfg_load  in  1  pulse: latch new configuration
- cfg_k1, cfg_k2, cfg_k3  in  8 each  rotor start positions
- cfg_rot_freq  in  3  rotor-1 steps every cfg_rot_freq+1 alpha chars
- cfg_shift_en  in  1  shift enable for pipe
- cfg_mode  in  1  1 = encrypt active
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_ready  out  1  controller accepts byte this cycle
- ret_credit  in  1  pipe retired one byte
- pipe_en  out  1  issue strobe to pipe
- pipe_din  out  8  byte to pipe
- pipe_k1, pipe_k2, pipe_k3  out  8 each  rotor positions used for this byte (0..25)
- pipe_rot_freq  out  3  configured rot_freq
- pipe_shift_en  out  1  configured shift enable
- pipe_shift_amt  out  4  (pipe_k1+pipe_k2+pipe_k3) mod 16
- pipe_mode  out  1  configured mode
- busy  out  1  state != RUN or credits in use
- credit_err  out  1  sticky: credit returned while counter full

Behaviour:
- Reset (rst=0, async):
  - State UNCFG; credits=CREDITS; rotors r1=r2=r3=0; step counter=0.
  - All pipe_* outputs 0; in_ready=0; busy=1; credit_err=0.
- States:
  - UNCFG: in_ready=0. cfg_load -> latch config, go to RUN next cycle.
  - RUN: in_ready = (credits>0), driven only from registered state/credits, never from in_valid. cfg_load -> DRAIN; in_ready drops the next cycle. A byte accepted in the same cycle as cfg_load is issued using the old configuration.
  - DRAIN: in_ready=0. Config captured at cfg_load entry is held; a further cfg_load overwrites it (last wins). When credits==CREDITS -> apply config, reset rotors to new keys and step counter to 0, go to RUN next cycle.
- Key reduction: cfg_kN stored as cfg_kN mod 26 (e.g. 27->1, 255->21).
- Issue: on in_valid&in_ready, next cycle:
  - pipe_en=1, pipe_din=in_data, pipe_k* = current rotors (pre-step), config fields from the active config.
  - pipe_en=0 in any cycle without accept; other pipe_* hold their last values.
  - Latency 1 cycle.
- Credits:
  - Accept decrements; ret_credit increments.
  - Both in the same cycle leaves the counter unchanged.
  - ret_credit at credits==CREDITS with no accept: ignored, credit_err set (cleared only by reset).
- Rotor stepping applies only to accepted bytes with active shift_en=1 and in_data in 65..90 or 97..122:
  - Step counter increments; when it reaches rot_freq it wraps to 0 and r1 steps. Rotor changes become visible on the next byte.
  - r1 steps 25->0 and carries into r2; r2 steps 25->0 and carries into r3; r3 wraps 25->0 with no carry.
  - Non-alpha bytes, and all bytes when shift_en=0, neither count nor step.
  - rot_freq=0: r1 steps on every alpha byte.
- pipe_shift_amt uses the 7-bit sum truncated to 4 bits (max sum 75).
- Reset mid-operation: all in-flight state is discarded, credits are restored to CREDITS, and the block returns to UNCFG.

Test Plan:
- Reset, then cfg_load k=(0,0,0), rot_freq=0, shift_en=1, mode=1; stream "ABC" with ret_credit held 1 -> pipe_k1 = 0,1,2; shift_amt 0,1,2; each pipe_en one cycle after accept.
- k1=25, k2=25, k3=3, rot_freq=0; send "a","b" -> byte1 k=(25,25,3), byte2 k=(0,0,4), shift_amt byte2 = 4.
- rot_freq=2, k=0; send "A1BC D" -> r1 steps only after the third alpha; the " " and "1" do not count; "D" issued with k1=1.
- CREDITS=4, ret_credit=0, in_valid held 1 -> exactly 4 accepts, then in_ready=0. One ret_credit -> exactly one more accept. Simultaneous accept+return -> counter unchanged.
- In RUN with 2 credits outstanding, cfg_load k1=30 -> in_ready=0 until both credits return; then r1=4 and RUN resumes; byte accepted in the cfg_load cycle carries old keys.
- ret_credit pulse with credits full -> credit_err=1 sticky, credits stay 4. Assert rst mid-stream -> all outputs 0, state UNCFG, in_ready=0 until next cfg_load.
